seq_ripple_addsub: RTL and testbench
====================================

Name: seq_ripple_addsub

Overview:
- Parametrised, multi-cycle ripple-carry adder/subtractor.
- Processes CHUNK bits per clock: a chain of CHUNK full-adder cells plus a carry register that links one chunk to the next.
- Trades latency for area on wide operands and adds subtract mode, signed overflow detection and a start/busy/done handshake.
- Sits in the arithmetic datapath and replaces fixed 4-bit combinational ripple adders where WIDTH is large.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.
- Derived: N = WIDTH/CHUNK, the number of RUN cycles.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only when not busy.
- sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored).
- a  input  WIDTH  operand A, sampled with accepted start.
- b  input  WIDTH  operand B, sampled with accepted start.
- cin  input  1  carry-in for add mode.
- busy  output  1  high while the operation is in progress.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result, registered.
- cout  output  1  carry-out of the MSB; in subtract mode, 1 = no borrow.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. Internal operand, carry and chunk-index registers are cleared.
- Reset asserted mid-operation aborts the operation: no done pulse, outputs stay at reset values.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: done=1 for exactly one cycle.
- Start acceptance: start is accepted at a rising edge when state is IDLE or DONE. start seen in RUN is ignored; there is no queueing.
- On acceptance:
  - latch A=a.
  - latch B=sub ? ~b : b.
  - carry = sub ? 1 : cin.
  - chunk index = 0.
  - go to RUN.
- RUN, each cycle:
  - Add chunk bits [i*CHUNK +: CHUNK] of A and B with the carry register through a CHUNK-bit ripple of full-adder cells (s = x^y^c; co = x&y | c&(x^y)).
  - Store the result bits in the internal result register.
  - Update the carry register and increment the index.
  - On the last chunk (i = N-1), also capture the carry into the MSB cell (c_msb).
- Exit from RUN: the edge that completes chunk N-1 moves to DONE and loads the outputs:
  - sum = full internal result.
  - cout = final carry.
  - ovf = c_msb ^ final carry.
- Latency: start high in cycle 0 -> busy high cycles 1..N -> done high in cycle N+1.
- Output hold: sum/cout/ovf change only on entry to DONE and hold until the next DONE or reset.
- After DONE:
  - no start: go to IDLE.
  - start in the DONE cycle: go directly to RUN (back-to-back; busy drops for exactly the DONE cycle).
- Arithmetic: all operations are modulo 2^WIDTH; no saturation.
- Operand changes on a/b/sub/cin after acceptance have no effect on the running operation.
- CHUNK=WIDTH: N=1, done in cycle 2.
- CHUNK=1: N=WIDTH, bit-serial operation.

Test Plan:
- WIDTH=16, CHUNK=4, sub=0, a=0x0003, b=0x0003, cin=1, start pulse in cycle 0 -> busy cycles 1-4, done cycle 5, sum=0x0007, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Start held high continuously, with operands changed during RUN:
  - first result matches the operands latched at acceptance.
  - second operation is accepted in the DONE cycle; its done arrives 5 cycles later.
  - busy is low only during the DONE cycles.
- rst_n pulsed low asynchronously (mid-cycle) during RUN cycle 2 -> all outputs 0 immediately, no done. A new start after release completes normally.
- Re-run the first two scenarios with CHUNK=1 (done in cycle 17) and CHUNK=16 (done in cycle 2). Also run 1000 random a/b/cin/sub vectors against a reference model: sum, cout and ovf must match exactly.

Source files
------------

// File: rtl/seq_ripple_addsub_if.sv
// seq_ripple_addsub_if: request/result bundle for seq_ripple_addsub
interface seq_ripple_addsub_if #(parameter int WIDTH = 16);
    logic start, sub, cin, busy, done, cout, ovf;
    logic [WIDTH-1:0] a, b, sum;
    modport master(output start, sub, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave(input start, sub, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/seq_ripple_addsub.sv
// seq_ripple_addsub: multi-cycle ripple-carry adder/subtractor, CHUNK bits per clock
module seq_ripple_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic clk,
    input logic rst_n,
    seq_ripple_addsub_if.slave bus
);
    localparam int N = WIDTH / CHUNK;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] op_a, op_b, res, res_nx;
    logic [IW-1:0] idx;
    logic [CHUNK-1:0] x, y, s;
    logic carry, cy, c_msb, last;
    assign x = op_a[idx*CHUNK +: CHUNK];
    assign y = op_b[idx*CHUNK +: CHUNK];
    assign last = idx == IW'(N - 1);
    // c_msb ends up as the carry into the top cell, needed for signed overflow
    always_comb begin
        cy = carry;
        c_msb = carry;
        s = '0;
        for (int k = 0; k < CHUNK; k++) begin
            c_msb = cy;
            s[k] = x[k] ^ y[k] ^ cy;
            cy = x[k] & y[k] | cy & (x[k] ^ y[k]);
        end
        res_nx = res;
        res_nx[idx*CHUNK +: CHUNK] = s;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum <= '0;
            bus.cout <= 1'b0;
            bus.ovf <= 1'b0;
            op_a <= '0;
            op_b <= '0;
            res <= '0;
            carry <= 1'b0;
            idx <= '0;
        end else if (state != RUN) begin
            bus.done <= 1'b0;
            if (bus.start) begin
                state <= RUN;
                bus.busy <= 1'b1;
                op_a <= bus.a;
                op_b <= bus.sub ? ~bus.b : bus.b;
                carry <= bus.sub | bus.cin;
                idx <= '0;
            end else begin
                state <= IDLE;
            end
        end else begin
            res <= res_nx;
            carry <= cy;
            idx <= last ? '0 : idx + 1'b1;
            if (last) begin
                state <= DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                bus.sum <= res_nx;
                bus.cout <= cy;
                bus.ovf <= c_msb ^ cy;
            end
        end
endmodule

// File: tb/tb_seq_ripple_addsub.sv
// tb_seq_ripple_addsub: scoreboard bench over CHUNK = 4, 1 and 16 instances sharing one stimulus
module tb_seq_ripple_addsub;
    localparam int W = 16;
    localparam int NCFG = 3;
    typedef struct {logic [W-1:0] sum; logic cout; logic ovf; int t;} exp_t;
    typedef struct {logic sub; logic [W-1:0] a, b; logic cin; logic [W-1:0] sum; logic cout, ovf;} vec_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic dbusy[NCFG], ddone[NCFG], dcout[NCFG], dovf[NCFG];
    logic [W-1:0] dsum[NCFG];
    exp_t q[NCFG][$];
    vec_t tbl[10];
    int nchk = 0, nfail = 0, cyc = 0;
    bit sb_on = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    for (genvar g = 0; g < NCFG; g++) begin : u
        localparam int CH = g == 0 ? 4 : g == 1 ? 1 : 16;
        seq_ripple_addsub_if #(.WIDTH(W)) bus ();
        assign bus.start = start;
        assign bus.sub = sub;
        assign bus.a = a;
        assign bus.b = b;
        assign bus.cin = cin;
        seq_ripple_addsub #(.WIDTH(W), .CHUNK(CH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
        assign dbusy[g] = bus.busy;
        assign ddone[g] = bus.done;
        assign dsum[g] = bus.sum;
        assign dcout[g] = bus.cout;
        assign dovf[g] = bus.ovf;
    end
    function automatic int lat(int k);
        return k == 0 ? W / 4 : k == 1 ? W : 1;
    endfunction
    function automatic exp_t model(logic s, logic [W-1:0] x, logic [W-1:0] y, logic c);
        logic [W:0] r;
        logic [W-1:0] yy;
        yy = s ? ~y : y;
        r = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s | c};
        model.sum = r[W-1:0];
        model.cout = r[W];
        model.ovf = x[W-1] == yy[W-1] && r[W-1] != x[W-1];
        model.t = 0;
    endfunction
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_on)
                for (int k = 0; k < NCFG; k++)
                    if (ddone[k]) begin
                        if (q[k].size() == 0) begin
                            check($sformatf("spurious_done_cfg%0d", k), 32'(ddone[k]), 32'(0));
                        end else begin
                            e = q[k].pop_front();
                            check($sformatf("sum_cfg%0d", k), 32'(dsum[k]), 32'(e.sum));
                            check($sformatf("cout_cfg%0d", k), 32'(dcout[k]), 32'(e.cout));
                            check($sformatf("ovf_cfg%0d", k), 32'(dovf[k]), 32'(e.ovf));
                            check($sformatf("latency_cfg%0d", k), 32'(cyc - e.t), 32'(lat(k)));
                        end
                    end
        end
    endtask
    // operands are scrambled right after acceptance to prove they were latched
    task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input exp_t e);
        @(negedge clk);
        sub = s;
        a = x;
        b = y;
        cin = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.t = cyc;
        for (int k = 0; k < NCFG; k++) q[k].push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub = ~s;
        cin = ~c;
        repeat (W + 2) @(negedge clk);
    endtask
    task automatic check_zero(input string nm, input int k);
        check({nm, "_busy"}, 32'(dbusy[k]), 32'(0));
        check({nm, "_done"}, 32'(ddone[k]), 32'(0));
        check({nm, "_sum"}, 32'(dsum[k]), 32'(0));
        check({nm, "_cout"}, 32'(dcout[k]), 32'(0));
        check({nm, "_ovf"}, 32'(dovf[k]), 32'(0));
    endtask
    task automatic stimulus();
        logic rs, rc;
        logic [W-1:0] ra, rb;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NCFG; k++) check_zero($sformatf("reset_cfg%0d", k), k);
        rst_n = 1'b1;
        sb_on = 1'b1;
        for (int i = 0; i < 10; i++)
            issue(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin, '{tbl[i].sum, tbl[i].cout, tbl[i].ovf, 0});
        for (int i = 0; i < 1000; i++) begin
            rs = 1'($urandom);
            rc = 1'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            issue(rs, ra, rb, rc, model(rs, ra, rb, rc));
        end
        sb_on = 1'b0;
        // start held high on the CHUNK=4 instance: back-to-back accept in each DONE cycle
        @(negedge clk);
        sub = 1'b0;
        cin = 1'b0;
        a = 16'h0010;
        b = 16'h0020;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("b2b_busy_c%0d", k), 32'(dbusy[0]), 32'(k != 5 && k != 10));
            check($sformatf("b2b_done_c%0d", k), 32'(ddone[0]), 32'(k == 5 || k == 10));
            if (k == 1) begin
                a = 16'h0100;
                b = 16'h0200;
            end
            if (k == 5) check("b2b_sum1", 32'(dsum[0]), 32'h0030);
            if (k == 10) check("b2b_sum2", 32'(dsum[0]), 32'h0300);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_busy_before", 32'(dbusy[0]), 32'(1));
        #2 rst_n = 1'b0;
        #1 check_zero("abort_now", 0);
        repeat (2) @(negedge clk);
        check_zero("abort_hold", 0);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        for (int k = 0; k < NCFG; k++) check_zero($sformatf("abort_after_cfg%0d", k), k);
        sb_on = 1'b1;
        issue(1'b0, 16'h0003, 16'h0003, 1'b1, '{16'h0007, 1'b0, 1'b0, 0});
        for (int k = 0; k < NCFG; k++) check($sformatf("drained_cfg%0d", k), 32'(q[k].size()), 32'(0));
    endtask
    initial begin
        tbl = '{
            '{1'b0, 16'h0003, 16'h0003, 1'b1, 16'h0007, 1'b0, 1'b0},
            '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
            '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
            '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0},
            '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1},
            '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0},
            '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1},
            '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0},
            '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0},
            '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 1'b1}
        };
        fork
            monitor();
            stimulus();
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
